// File: rtl/senha_verificador.sv
// senha_verificador: keypad digit-packet consumer and lock controller.
// Accepts a 20-nibble packet on the rising edge of digitos_valid, classifies
// it (CANCEL / TIMEOUT / VAZIO / CODIGO) and runs the lock FSM: unlock on a
// password match, error display and failure counting with lockout, and a
// master-code program mode that stores a new password.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   digitos_value[79:0] packed nibbles, nibble 0 = most recent key, F = empty
//   digitos_valid       packet valid (level, may be held)
//   tranca_aberta       lock open
//   erro                wrong code / rejected new password
//   bloqueado           lockout active
//   modo_prog           program mode active
//   senha_alterada      1-cycle pulse when a new password is stored
//   falhas              consecutive failure count
//   alarme              alarm, only built with SENHA_VERIFICADOR_ALARME_EN
//
// Optional build macro: SENHA_VERIFICADOR_ALARME_EN (alarm during lockout and
// for T_BLOQUEIO cycles after it; otherwise alarme is tied to 0).
module senha_verificador #(
  parameter logic [79:0] SENHA_INICIAL = 80'hFFFF_FFFF_FFFF_FFFF_1234,
  parameter logic [79:0] SENHA_MESTRE  = 80'hFFFF_FFFF_FFFF_FF99_9999,
  parameter int T_ABERTO    = 50,
  parameter int T_ERRO      = 10,
  parameter int T_BLOQUEIO  = 200,
  parameter int T_PROG      = 1000,
  parameter int MAX_FALHAS  = 3,
  parameter int MIN_DIGITOS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [79:0]                       digitos_value,
  input  logic                              digitos_valid,
  output logic                              tranca_aberta,
  output logic                              erro,
  output logic                              bloqueado,
  output logic                              modo_prog,
  output logic                              senha_alterada,
  output logic [$clog2(MAX_FALHAS+1)-1:0]   falhas,
  output logic                              alarme
);

  localparam int FW   = $clog2(MAX_FALHAS + 1);
  localparam int TM1  = (T_ABERTO > T_ERRO) ? T_ABERTO : T_ERRO;
  localparam int TM2  = (T_BLOQUEIO > T_PROG) ? T_BLOQUEIO : T_PROG;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [79:0] TODOS_B = {20{4'hB}};
  localparam logic [79:0] TODOS_E = {20{4'hE}};
  localparam logic [79:0] TODOS_F = {20{4'hF}};

  typedef enum logic [2:0] {ESPERA, ABERTO, ERRO, BLOQUEIO, PROG} estado_t;
  typedef enum logic [1:0] {CODIGO, CANCEL, TIMEOUT, VAZIO} tipo_t;

  estado_t         estado;
  logic [TW-1:0]   timer;
  logic [79:0]     senha;
  logic            valid_q;
  logic            orig_prog;   // ERRO returns to PROG instead of ESPERA

  logic            aceita;
  tipo_t           tipo;
  logic [4:0]      len;
  logic            contiguo;
  logic            fim;
  logic [FW:0]     falhas_inc;
  logic            codigo_espera;
  logic            abre;
  logic            mestre;
  logic            bloqueia;

  assign aceita = digitos_valid & ~valid_q;

  always_comb begin
    tipo = CODIGO;
    if (digitos_value == TODOS_B)      tipo = CANCEL;
    else if (digitos_value == TODOS_E) tipo = TIMEOUT;
    else if (digitos_value == TODOS_F) tipo = VAZIO;
  end

  // New password must be a contiguous run of digits from nibble 0 with only
  // F padding above it; a digit after an F makes the packet invalid.
  always_comb begin
    len      = 5'd0;
    contiguo = 1'b1;
    fim      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (digitos_value[4*i +: 4] != 4'hF) begin
        if (fim) contiguo = 1'b0;
        else     len      = len + 5'd1;
      end else begin
        fim = 1'b1;
      end
    end
  end

  assign falhas_inc    = {1'b0, falhas} + {{FW{1'b0}}, 1'b1};
  assign codigo_espera = (estado == ESPERA) && aceita && (tipo == CODIGO);
  // Stored password is checked first, so it wins if it equals the master code.
  assign abre          = codigo_espera && (digitos_value == senha);
  assign mestre        = codigo_espera && !abre && (digitos_value == SENHA_MESTRE);
  assign bloqueia      = codigo_espera && !abre && !mestre &&
                         (falhas_inc == (FW+1)'(MAX_FALHAS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado         <= ESPERA;
      timer          <= '0;
      senha          <= SENHA_INICIAL;
      valid_q        <= 1'b1;  // ignore a packet already valid at release
      orig_prog      <= 1'b0;
      falhas         <= '0;
      tranca_aberta  <= 1'b0;
      erro           <= 1'b0;
      bloqueado      <= 1'b0;
      modo_prog      <= 1'b0;
      senha_alterada <= 1'b0;
    end else begin
      valid_q        <= digitos_valid;
      senha_alterada <= 1'b0;
      case (estado)
        ESPERA: begin
          if (abre) begin
            estado        <= ABERTO;
            timer         <= TW'(T_ABERTO - 1);
            falhas        <= '0;
            tranca_aberta <= 1'b1;
          end else if (mestre) begin
            estado    <= PROG;
            timer     <= TW'(T_PROG - 1);
            modo_prog <= 1'b1;
          end else if (bloqueia) begin
            estado    <= BLOQUEIO;
            timer     <= TW'(T_BLOQUEIO - 1);
            falhas    <= falhas_inc[FW-1:0];
            bloqueado <= 1'b1;
          end else if (codigo_espera) begin
            estado    <= ERRO;
            timer     <= TW'(T_ERRO - 1);
            falhas    <= falhas_inc[FW-1:0];
            orig_prog <= 1'b0;
            erro      <= 1'b1;
          end
        end
        ABERTO: begin
          if (timer == '0) begin
            estado        <= ESPERA;
            tranca_aberta <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ERRO: begin
          if (timer == '0) begin
            erro <= 1'b0;
            if (orig_prog) begin
              estado    <= PROG;
              timer     <= TW'(T_PROG - 1);
              modo_prog <= 1'b1;
            end else begin
              estado <= ESPERA;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BLOQUEIO: begin
          if (timer == '0) begin
            estado    <= ESPERA;
            falhas    <= '0;
            bloqueado <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PROG: begin
          if (aceita) begin
            case (tipo)
              CANCEL, TIMEOUT: begin
                estado    <= ESPERA;
                modo_prog <= 1'b0;
              end
              VAZIO: timer <= TW'(T_PROG - 1);
              default: begin
                modo_prog <= 1'b0;
                if (contiguo && (len >= 5'(MIN_DIGITOS))) begin
                  estado         <= ESPERA;
                  senha          <= digitos_value;
                  senha_alterada <= 1'b1;
                end else begin
                  estado    <= ERRO;
                  timer     <= TW'(T_ERRO - 1);
                  orig_prog <= 1'b1;
                  erro      <= 1'b1;
                end
              end
            endcase
          end else if (timer == '0) begin
            estado    <= ESPERA;
            modo_prog <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          estado         <= ESPERA;
          tranca_aberta  <= 1'b0;
          erro           <= 1'b0;
          bloqueado      <= 1'b0;
          modo_prog      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SENHA_VERIFICADOR_ALARME_EN
  logic [TW-1:0] alarme_cnt;

  // Counter is held at T_BLOQUEIO-1 throughout lockout, so the tail after
  // exit lasts exactly T_BLOQUEIO cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarme     <= 1'b0;
      alarme_cnt <= '0;
    end else if (abre) begin
      alarme <= 1'b0;
    end else if (bloqueia || estado == BLOQUEIO) begin
      alarme     <= 1'b1;
      alarme_cnt <= TW'(T_BLOQUEIO - 1);
    end else if (alarme) begin
      if (alarme_cnt == '0) alarme <= 1'b0;
      else                  alarme_cnt <= alarme_cnt - 1'b1;
    end
  end
`else
  assign alarme = 1'b0;
`endif

endmodule

// File: tb/tb_senha_verificador.sv
// Directed self-checking bench for senha_verificador (default parameters).
module tb_senha_verificador;

  localparam logic [79:0] P1234  = 80'hFFFF_FFFF_FFFF_FFFF_1234;
  localparam logic [79:0] P1235  = 80'hFFFF_FFFF_FFFF_FFFF_1235;
  localparam logic [79:0] P5678  = 80'hFFFF_FFFF_FFFF_FFFF_5678;
  localparam logic [79:0] MESTRE = 80'hFFFF_FFFF_FFFF_FF99_9999;
  localparam logic [79:0] P12    = 80'hFFFF_FFFF_FFFF_FFFF_FF12;
  localparam logic [79:0] PGAP   = 80'hFFFF_FFFF_FFFF_FFF1_2F34;
  localparam logic [79:0] ALLB   = {20{4'hB}};
  localparam logic [79:0] ALLE   = {20{4'hE}};
  localparam logic [79:0] ALLF   = {20{4'hF}};

`ifdef SENHA_VERIFICADOR_ALARME_EN
  localparam logic ALARME_LOCK = 1'b1;
`else
  localparam logic ALARME_LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] digitos_value = ALLF;
  logic        digitos_valid = 1'b0;
  logic        tranca_aberta, erro, bloqueado, modo_prog, senha_alterada, alarme;
  logic [1:0]  falhas;

  int checks = 0;
  int errors = 0;

  senha_verificador dut (
    .clk(clk), .rst(rst),
    .digitos_value(digitos_value), .digitos_valid(digitos_valid),
    .tranca_aberta(tranca_aberta), .erro(erro), .bloqueado(bloqueado),
    .modo_prog(modo_prog), .senha_alterada(senha_alterada),
    .falhas(falhas), .alarme(alarme)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle (guarantees a fresh edge), then a one-cycle valid strobe.
  // Returns in cycle N+1 of the accepted packet.
  task automatic send(input logic [79:0] v);
    digitos_valid = 1'b0;
    digitos_value = ALLF;
    tick();
    digitos_valid = 1'b1;
    digitos_value = v;
    tick();
    digitos_valid = 1'b0;
    digitos_value = ALLF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    digitos_valid = 1'b1;
    digitos_value = P1234;
    tick(); tick();
    checks++;
    if ({tranca_aberta, erro, bloqueado, modo_prog, senha_alterada, alarme, falhas} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {tranca_aberta, erro, bloqueado, modo_prog, senha_alterada, alarme, falhas});
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (tranca_aberta !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_valid tranca got %b want 0", tranca_aberta);
    end
    digitos_valid = 1'b0;
    digitos_value = ALLF;
    tick();
  endtask

  task automatic test_ignored_espera();
    send(ALLE);
    send(ALLB);
    checks++;
    if ({tranca_aberta, erro, bloqueado, modo_prog, falhas} !== 6'b0) begin
      errors++;
      $display("FAIL ignore_cancel_timeout got %b want 000000",
               {tranca_aberta, erro, bloqueado, modo_prog, falhas});
    end
  endtask

  task automatic test_abrir(input logic [79:0] v);
    int n;
    send(v);
    checks++;
    if (tranca_aberta !== 1'b1 || falhas !== 2'd0) begin
      errors++;
      $display("FAIL abrir_n1 tranca %b falhas %0d want 1 0", tranca_aberta, falhas);
    end
    n = 0;
    while (tranca_aberta === 1'b1 && n < 500) begin n++; tick(); end
    checks++;
    if (n != 50) begin
      errors++;
      $display("FAIL abrir_dur got %0d want 50", n);
    end
  endtask

  task automatic test_bloqueio();
    int n;
    for (int k = 1; k <= 2; k++) begin
      send(P1235);
      checks++;
      if (erro !== 1'b1 || falhas !== 2'(k)) begin
        errors++;
        $display("FAIL falha_%0d erro %b falhas %0d want 1 %0d", k, erro, falhas, k);
      end
      n = 0;
      while (erro === 1'b1 && n < 500) begin n++; tick(); end
      checks++;
      if (n != 10) begin
        errors++;
        $display("FAIL erro_dur got %0d want 10", n);
      end
    end
    send(P1235);
    checks++;
    if (bloqueado !== 1'b1 || falhas !== 2'd3 || erro !== 1'b0 || alarme !== ALARME_LOCK) begin
      errors++;
      $display("FAIL bloqueio_ini bloq %b falhas %0d erro %b alarme %b want 1 3 0 %b",
               bloqueado, falhas, erro, alarme, ALARME_LOCK);
    end
    n = 0;
    while (bloqueado === 1'b1 && n < 1000) begin
      n++;
      digitos_valid = (n == 20);
      digitos_value = (n == 20) ? P1234 : ALLF;
      tick();
      if (tranca_aberta !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL bloqueio_ignora tranca got %b want 0", tranca_aberta);
      end
    end
    checks++;
    if (n != 200 || falhas !== 2'd0 || tranca_aberta !== 1'b0) begin
      errors++;
      $display("FAIL bloqueio_fim dur %0d falhas %0d tranca %b want 200 0 0",
               n, falhas, tranca_aberta);
    end
    digitos_valid = 1'b0;
`ifdef SENHA_VERIFICADOR_ALARME_EN
    test_abrir(P1234);
    checks++;
    if (alarme !== 1'b0) begin
      errors++;
      $display("FAIL alarme_clear got %b want 0", alarme);
    end
`endif
  endtask

  task automatic test_held();
    int n, subidas;
    logic prev;
    digitos_valid = 1'b1;
    digitos_value = P1234;
    n = 0; subidas = 0; prev = 1'b0;
    for (int c = 0; c < 120; c++) begin
      if (c == 5) digitos_value = ALLF;
      if (c == 8) digitos_valid = 1'b0;
      tick();
      if (tranca_aberta === 1'b1) n++;
      if (tranca_aberta === 1'b1 && !prev) subidas++;
      prev = tranca_aberta;
    end
    checks++;
    if (n != 50 || subidas != 1) begin
      errors++;
      $display("FAIL held_valid open_cycles %0d rises %0d want 50 1", n, subidas);
    end
  endtask

  task automatic wait_erro_clear();
    int n = 0;
    while (erro === 1'b1 && n < 500) begin n++; tick(); end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL erro_wait got %0d want 10", n);
    end
  endtask

  task automatic test_prog();
    send(MESTRE);
    checks++;
    if (modo_prog !== 1'b1 || erro !== 1'b0) begin
      errors++;
      $display("FAIL prog_enter modo %b erro %b want 1 0", modo_prog, erro);
    end
    send(P5678);
    checks++;
    if (senha_alterada !== 1'b1 || modo_prog !== 1'b0) begin
      errors++;
      $display("FAIL prog_store alterada %b modo %b want 1 0", senha_alterada, modo_prog);
    end
    tick();
    checks++;
    if (senha_alterada !== 1'b0) begin
      errors++;
      $display("FAIL prog_pulse got %b want 0", senha_alterada);
    end
    send(P1234);
    checks++;
    if (erro !== 1'b1 || falhas !== 2'd1) begin
      errors++;
      $display("FAIL old_pw_rejected erro %b falhas %0d want 1 1", erro, falhas);
    end
    wait_erro_clear();
    test_abrir(P5678);
  endtask

  task automatic test_prog_erros();
    int n;
    send(MESTRE);
    send(P12);
    checks++;
    if (erro !== 1'b1 || modo_prog !== 1'b0 || falhas !== 2'd0) begin
      errors++;
      $display("FAIL prog_curta erro %b modo %b falhas %0d want 1 0 0", erro, modo_prog, falhas);
    end
    wait_erro_clear();
    checks++;
    if (modo_prog !== 1'b1) begin
      errors++;
      $display("FAIL prog_volta got %b want 1", modo_prog);
    end
    send(PGAP);
    checks++;
    if (erro !== 1'b1 || senha_alterada !== 1'b0) begin
      errors++;
      $display("FAIL prog_lacuna erro %b alterada %b want 1 0", erro, senha_alterada);
    end
    wait_erro_clear();
    send(ALLB);
    checks++;
    if (modo_prog !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL prog_cancel modo %b erro %b want 0 0", modo_prog, erro);
    end
    send(MESTRE);
    n = 0;
    while (modo_prog === 1'b1 && n < 3000) begin n++; tick(); end
    checks++;
    if (n != 1000) begin
      errors++;
      $display("FAIL prog_timeout got %0d want 1000", n);
    end
  endtask

  task automatic test_reset_mid();
    send(P5678);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({tranca_aberta, erro, bloqueado, modo_prog, senha_alterada, alarme, falhas} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid got %b want 00000000",
               {tranca_aberta, erro, bloqueado, modo_prog, senha_alterada, alarme, falhas});
    end
    tick();
    rst = 1'b0;
    tick();
    test_abrir(P1234);
  endtask

  initial begin
    test_reset();
    test_ignored_espera();
    test_abrir(P1234);
    test_bloqueio();
    test_held();
    test_prog();
    test_prog_erros();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/senha_verificador.md
Name: senha_verificador

Overview:
- Consumer end of the keypad digit-packet interface: takes the 20-nibble digit packet and its valid strobe from the keypad decoder, classifies each packet, and runs the lock controller.
- Lock-controller functions: compare against the stored password, unlock timer, failure counting with lockout, and a master-code program mode for changing the password.
- Sits between the keypad decoder and the top-level lock/LED outputs.

Parameters:
- SENHA_INICIAL, 80'hFFFF_FFFF_FFFF_FFFF_1234: password loaded at reset; 20 nibbles, F = empty.
- SENHA_MESTRE, 80'hFFFF_FFFF_FFFF_FF99_9999: master code that enters program mode.
- T_ABERTO, 50: cycles the lock stays open.
- T_ERRO, 10: cycles the error indication is shown.
- T_BLOQUEIO, 200: lockout duration in cycles.
- T_PROG, 1000: program-mode inactivity timeout in cycles.
- MAX_FALHAS, 3: consecutive failures that trigger lockout (≥1).
- MIN_DIGITOS, 4: minimum length of a new password (1..20).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous reset, active-high.
- digitos_value, input, 80: packed 20×4-bit packet; nibble 0 = most recent key, F = empty.
- digitos_valid, input, 1: packet valid; may stay high for several cycles.
- tranca_aberta, output, 1: lock open.
- erro, output, 1: wrong-code / rejected-password indication.
- bloqueado, output, 1: lockout active.
- modo_prog, output, 1: program mode active.
- senha_alterada, output, 1: 1-cycle pulse when a new password is stored.
- falhas, output, $clog2(MAX_FALHAS+1): consecutive failure count.
- alarme, output, 1: alarm (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0; falhas = 0.
  - State ESPERA; senha = SENHA_INICIAL; timer = 0.
  - valid_q = 1, so a packet already valid when reset releases is ignored.
  - Reset mid-operation restores all of the above; a password changed in program mode is lost.
- Packet capture:
  - A packet is accepted only on a rising edge: digitos_valid=1 and valid_q=0. valid_q is registered every cycle.
  - digitos_value is sampled in that same cycle. Later cycles of a held valid are ignored, including the all-F clear packet that follows.
- Classification of the sampled value:
  - All nibbles B: CANCEL.
  - All nibbles E: TIMEOUT.
  - All nibbles F: VAZIO, always ignored.
  - Anything else: CODIGO.
- Latency: a packet accepted in cycle N changes state and outputs in cycle N+1. Outputs are decoded from the state register only.
- Timers: the timer loads T−1 on state entry, decrements each cycle, and the state exits on the cycle it reads 0. A T-cycle state is therefore held for exactly T cycles.
- ESPERA:
  - CODIGO == senha → ABERTO; falhas = 0.
  - Else CODIGO == SENHA_MESTRE → PROG; falhas unchanged.
  - Else CODIGO: falhas += 1. If the new value equals MAX_FALHAS → BLOQUEIO, else → ERRO.
  - CANCEL, TIMEOUT and VAZIO are ignored.
  - If senha == SENHA_MESTRE, the unlock check wins.
- ABERTO: tranca_aberta = 1 for T_ABERTO cycles, then ESPERA. Packets are ignored.
- ERRO: erro = 1 for T_ERRO cycles, then return to the origin state (ESPERA or PROG, remembered on entry). Packets are ignored.
- BLOQUEIO: bloqueado = 1 for T_BLOQUEIO cycles; on exit falhas = 0 → ESPERA. Packets are ignored.
- PROG:
  - modo_prog = 1. The timer runs T_PROG and restarts on every accepted packet; expiry → ESPERA.
  - CANCEL or TIMEOUT → ESPERA; VAZIO is ignored.
  - CODIGO: len = count of consecutive non-F nibbles starting at nibble 0. Nibbles above len must all be F, else the packet is invalid.
  - Valid and len ≥ MIN_DIGITOS → senha = value; senha_alterada pulses in cycle N+1; → ESPERA.
  - Otherwise → ERRO (falhas unchanged), then return to PROG with a fresh T_PROG.
  - CODIGO equal to SENHA_MESTRE is stored like any other value.
- Comparisons are full 80-bit equality, so F padding makes length significant.
- falhas saturates at MAX_FALHAS.

Optional Feature:
- Macro SENHA_VERIFICADOR_ALARME_EN.
- Defined: alarme = 1 while in BLOQUEIO and for T_BLOQUEIO further cycles after exit. A CODIGO matching senha in ESPERA clears alarme immediately, in the same cycle ABERTO is entered.
- Undefined: alarme is tied to 0 and no extra logic is built.

Test Plan:
- Keys 1,2,3,4 then confirm: valid edge with value …F1234 → tranca_aberta high in cycles N+1..N+50, falhas = 0, then ESPERA.
- Wrong code …F1235 three times, each after ERRO clears: falhas goes 1, 2; the third gives bloqueado = 1 for 200 cycles. A packet …F1234 during lockout is ignored. Afterwards falhas = 0.
- Valid held high 5 cycles with …F1234, followed by all-F with valid still high: exactly one acceptance and one 50-cycle open.
- Master code …999999, then …F5678 → modo_prog in N+1, senha_alterada pulse. Then …F1234 gives erro, …F5678 opens.
- In PROG: …FF12 (len 2 < 4) gives erro for 10 cycles, then back to PROG. An all-B packet returns to ESPERA. No packet for 1000 cycles returns to ESPERA.
- Assert rst during ABERTO and after a password change → all outputs 0, senha reverts (…F1234 opens). A valid already high at rst release is not accepted.
